// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared GPS path types and constants
package gps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int GPS_B = 8;

    localparam logic [7:0] NMEA_DOLLAR = 8'h24;
    localparam logic [7:0] NMEA_STAR   = 8'h2A;
    localparam logic [7:0] NMEA_COMMA  = 8'h2C;

endpackage

// File: rtl/gps_rx_sync.sv
// rtl/gps_rx_sync.sv - two-flop synchroniser for asynchronous GPS inputs, idles high
module gps_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic stage1;

    // Resets to 1 so an idle-high line never looks like a falling edge after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stage1 <= 1'b1;
            dout   <= 1'b1;
        end else begin
            stage1 <= din;
            dout   <= stage1;
        end
    end

endmodule

// File: rtl/gps_uart_rx.sv
// rtl/gps_uart_rx.sv - 8N1 UART receiver feeding the GPS byte interface
module gps_uart_rx
    import gps_pkg::*;
#(
    parameter int CLOCK_HZ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int B        = GPS_B
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx,
    output logic [B-1:0] data,
    output logic         load,
    output logic         framing_error,
    output logic         busy
);

    localparam int BIT_CYCLES = CLOCK_HZ / BAUD;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES);
    localparam int BW         = $clog2(B + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(B - 1);

    if (BIT_CYCLES < 4) begin : g_bit_cycles_check
        $error("gps_uart_rx: CLOCK_HZ/BAUD must be at least 4");
    end

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bitcnt;
    logic [B-1:0]  shreg;
    logic          rx_s;
    logic          rx_prev;

    gps_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .din   (rx),
        .dout  (rx_s)
    );

    // One-cycle delayed copy of the synchronised line for falling-edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    // Frame FSM: start qualification at mid start bit, then one sample per bit period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bitcnt        <= '0;
            shreg         <= '0;
            data          <= '0;
            load          <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            load          <= 1'b0;
            framing_error <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // Only a fresh high-to-low transition starts a frame.
                    if (rx_prev && !rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        if (rx_s) begin
                            // Line already back high at mid start bit: a glitch.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= ST_DATA;
                            cnt    <= '0;
                            bitcnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        // LSB arrives first, so shift in at the top and move right.
                        shreg <= {rx_s, shreg[B-1:1]};
                        cnt   <= '0;
                        if (bitcnt == BITS_LAST) begin
                            state  <= ST_STOP;
                            bitcnt <= '0;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        if (rx_s) begin
                            data <= shreg;
                            load <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                        end
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb/tb_gps_uart_rx.sv - scoreboard bench for gps_uart_rx with random frames
module tb_gps_uart_rx;

    localparam int CLOCK_HZ = 8;
    localparam int BAUD     = 1;
    localparam int B        = 8;
    localparam int BITC     = CLOCK_HZ / BAUD;
    localparam int HALF     = BITC / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       load;
    logic       framing_error;
    logic       busy;

    gps_uart_rx #(
        .CLOCK_HZ (CLOCK_HZ),
        .BAUD     (BAUD),
        .B        (B)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .load          (load),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         err;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] model_data = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard, data tracks last good byte.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            model_data = 8'h00;
            check("reset_strobes", {load, framing_error}, 0);
        end else if (load || framing_error) begin
            check("strobe_exclusive", load && framing_error, 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {load, framing_error}, 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind_err", framing_error, e.err);
                check("strobe_cycle", cyc, e.cyc);
                if (!e.err) model_data = e.b;
            end
        end
        check("data_hold", data, model_data);
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1 rx = v;
        end
    endtask

    // Expected strobe lands after the stop-bit sample edge E(2+HALF+(B+1)*BITC).
    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t e;
        int   e0;
        @(negedge clock);
        #1 rx = 1'b0;
        e0    = cyc + 1;
        e.err = !stop;
        e.b   = b;
        e.cyc = e0 + 2 + HALF + (B + 1) * BITC;
        sb.push_back(e);
        drive(1'b0, BITC - 1);
        for (int k = 0; k < B; k++) drive(b[k], BITC);
        drive(stop, BITC);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] gpzda [6];
        int         e0;
        logic [7:0] rb;
        logic       rstop;
        logic       prev_bad;
        gpzda = '{8'h24, 8'h47, 8'h50, 8'h5A, 8'h44, 8'h41};

        // Reset held with rx toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_busy", busy, 0);
            check("reset_data", data, 0);
            #1 rx = i[0];
        end
        @(negedge clock);
        #1 reset = 1'b1;
        rx = 1'b1;
        drive(1'b1, 4);

        // Single '$' frame with busy window.
        fork
            send_frame(8'h24, 1'b1);
            begin
                int e0b;
                @(negedge clock);
                e0b = cyc + 1;
                for (int j = 0; j < 80; j++) begin
                    @(negedge clock);
                    check("busy_dollar", busy, (cyc >= e0b + 2 && cyc <= e0b + 77));
                end
            end
        join
        drive(1'b1, 4);
        drain();
        check("dollar_data", data, 8'h24);

        // Back-to-back "$GPZDA" with no idle gap.
        foreach (gpzda[i]) send_frame(gpzda[i], 1'b1);
        drain();

        // Bad stop bit, then a good frame once the line returns high.
        send_frame(8'h36, 1'b0);
        drive(1'b1, 2);
        send_frame(8'h45, 1'b1);
        drive(1'b1, 4);
        drain();
        check("after_ferr_data", data, 8'h45);

        // Two-cycle low glitch: START entered, back in IDLE at E6.
        @(negedge clock);
        #1 rx = 1'b0;
        e0 = cyc + 1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            if (cyc == e0 + 3) check("glitch_busy_hi", busy, 1);
            if (cyc == e0 + 6) check("glitch_busy_lo", busy, 0);
            #1 rx = (j == 0) ? 1'b0 : 1'b1;
        end

        // Line held low for 20 bit times: exactly one framing error.
        @(negedge clock);
        #1 rx = 1'b0;
        e0 = cyc + 1;
        sb.push_back('{err: 1'b1, b: 8'h00, cyc: e0 + 2 + HALF + (B + 1) * BITC});
        drive(1'b0, 20 * BITC - 1);
        @(negedge clock);
        check("held_low_busy", busy, 0);
        check("held_low_pending", sb.size(), 0);
        drive(1'b1, 3);
        send_frame(8'h47, 1'b1);
        drive(1'b1, 2);
        drain();

        // Reset pulse during data bit 3 abandons the frame.
        drive(1'b0, BITC);
        drive(1'b1, BITC);
        drive(1'b0, BITC);
        drive(1'b1, BITC);
        drive(1'b0, 4);
        @(negedge clock);
        check("mid_frame_busy", busy, 1);
        #1 reset = 1'b0;
        rx = 1'b1;
        @(negedge clock);
        check("reset_mid_busy", busy, 0);
        check("reset_mid_data", data, 0);
        #1 reset = 1'b1;
        drive(1'b1, 10);
        send_frame(8'h2A, 1'b1);
        drive(1'b1, 2);
        drain();
        check("star_data", data, 8'h2A);

        // Random frames, gaps, bad stops and short glitches.
        prev_bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                drive(1'b1, 1);
                drive(1'b0, $urandom_range(1, 3));
                drive(1'b1, 8);
                prev_bad = 1'b0;
            end
            drive(1'b1, $urandom_range(prev_bad ? 1 : 0, 3));
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 6) != 0);
            send_frame(rb, rstop);
            prev_bad = !rstop;
        end
        drive(1'b1, 4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gps_uart_rx.md
Name: gps_uart_rx

Overview:
- Serial front end of the GPS path: turns the receiver module's 8N1 UART line into bytes.
- Each accepted byte drives `data` with a one-cycle `load` strobe, directly feeding the GpsReceiver byte interface (`data[7:0]`, `load`).
- Performs input synchronisation, start-bit glitch rejection, mid-bit sampling and stop-bit checking.
- No buffering: the downstream stage consumes every strobe in the cycle it is issued.

Parameters:
- CLOCK_HZ, 50_000_000, system clock frequency.
- BAUD, 9600, line rate. BIT_CYCLES = CLOCK_HZ/BAUD (integer division); HALF = BIT_CYCLES/2.
- B, 8, data bits per frame. Fixed at 8 for NMEA; the parameter exists for bench use only.
- Legal range: BIT_CYCLES ≥ 4. Smaller values are illegal and trapped by an elaboration-time check.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- rx  input  1  asynchronous UART line, idle high.
- data  output  B  last good byte; stable between strobes.
- load  output  1  one-cycle strobe: `data` is a new valid byte.
- framing_error  output  1  one-cycle strobe: stop bit sampled low; byte discarded.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, data=0, load=0, framing_error=0, busy=0, bit counter=0, cycle counter=0.
  - Both sync flops and rx_prev load 1.
  - Reset mid-frame abandons the frame with no strobe.
- Synchroniser: rx → sync1 → rx_s (2 flops). rx_prev is a register of rx_s. At edge En, rx_s equals rx as sampled at E(n-2).
- Timing reference: E0 = first edge sampling rx==0 after idle-high.
- State IDLE:
  - On rx_prev==1 and rx_s==0 (occurs at E2): go to START, cnt=0.
  - A line held low never triggers; a fresh high→low edge is required.
- State START:
  - Each edge: if cnt==HALF-1, decide; otherwise cnt++.
  - Decision at E(2+HALF):
    - rx_s==1: glitch, go to IDLE, no strobe.
    - rx_s==0: go to DATA, cnt=0, bitcnt=0.
- State DATA:
  - At cnt==BIT_CYCLES-1: shift rx_s into the shift register MSB, shift right (LSB-first line order), cnt=0, bitcnt++.
  - Otherwise cnt++.
  - After B bits: go to STOP. Bit k is sampled at E(2+HALF+(k+1)·BIT_CYCLES).
- State STOP:
  - At cnt==BIT_CYCLES-1, edge E(2+HALF+(B+1)·BIT_CYCLES):
    - rx_s==1: data<=shift register, load=1 for exactly one cycle.
    - rx_s==0: framing_error=1 for one cycle; data unchanged.
  - Either way, return to IDLE in the same edge.
  - Returning from mid-stop-bit means a back-to-back start edge is caught with no lost frame. Tolerated baud mismatch is up to ±HALF cycles accumulated over a frame.
- Strobes:
  - load and framing_error are mutually exclusive and never high on consecutive cycles for one frame.
  - busy=1 from the IDLE→START edge through the STOP decision edge inclusive.
- Arithmetic: counters are sized with $clog2(BIT_CYCLES) and $clog2(B+1), unsigned, with no wrap in legal operation.

Decomposition:
- Shared package gps_pkg:
  - FSM state encoding constants (IDLE/START/DATA/STOP, 2 bits).
  - Byte width B=8.
  - NMEA character constants ('$'=8'h24, '*'=8'h2A, ','=8'h2C), also used by GpsReceiver.
- Sub-module gps_rx_sync: 2-flop synchroniser with reset value 1, reused for any other async GPS input (PPS).

Test Plan (CLOCK_HZ=8, BAUD=1, so BIT_CYCLES=8, HALF=4):
- Reset: hold reset=0 for 3 cycles with rx toggling → data=0, load=0, framing_error=0, busy=0 throughout.
- Single frame '$' (8'h24), start bit at E0 → load=1 only in the cycle after E78; data=8'h24 from then on; busy high E2..E78.
- Back-to-back "$GPZDA" (8'h24,47,50,5A,44,41) with no idle gap → six load strobes 80 cycles apart, bytes in order, framing_error never high.
- Frame 8'h36 with stop bit driven 0 → framing_error one cycle after E78, load stays 0, data keeps its previous value; a following good 8'h45 is received normally after rx returns high.
- Low glitch of 2 cycles → START entered, returns to IDLE at E6, no strobes. Line held low for 20 bit times → exactly one framing_error, then silence until rx rises and falls again.
- reset=0 pulsed during data bit 3 → state IDLE next cycle, no strobe. A subsequent clean 8'h2A frame yields load with data=8'h2A.
